// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined MIPS control unit (D decode, E / M1..M[MEM_LAT] / W control registers).
// Optional macro CTL_ILLEGAL_TRAP_EN carries an illegal-instruction flag through to illegal_w.
module pipe_ctrl_unit #(
   parameter int MEM_LAT   = 1,
   parameter int ALUCTRL_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 zero_e,
   input  logic                 stall,
   input  logic                 flush_e,
   output logic                 jump_d,
   output logic                 alu_src_e,
   output logic                 reg_dst_e,
   output logic                 zero_ext_e,
   output logic [ALUCTRL_W-1:0] alu_control_e,
   output logic                 reg_write_e,
   output logic                 mem_to_reg_e,
   output logic                 mem_write_m,
   output logic                 reg_write_m,
   output logic                 mem_to_reg_m,
   output logic                 pcsrc_m,
   output logic                 reg_write_w,
   output logic                 mem_to_reg_w,
   output logic                 valid_w,
   output logic                 illegal_w
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   // D stage: combinational decode
   logic                 alu_src_p0, reg_dst_p0, zero_ext_p0;
   logic                 rw_p0, m2r_p0, mw_p0, beq_p0, bne_p0, bad_p0;
   logic [ALUCTRL_W-1:0] alu_p0;

   always_comb begin
      alu_src_p0  = 1'b0;
      reg_dst_p0  = 1'b0;
      zero_ext_p0 = 1'b0;
      rw_p0       = 1'b0;
      m2r_p0      = 1'b0;
      mw_p0       = 1'b0;
      beq_p0      = 1'b0;
      bne_p0      = 1'b0;
      bad_p0      = 1'b0;
      alu_p0      = '0;
      case (op)
         OP_RTYPE: begin
            rw_p0      = 1'b1;
            reg_dst_p0 = 1'b1;
            case (funct)
               FN_ADD:  alu_p0 = ALUCTRL_W'(4'b0010);
               FN_SUB:  alu_p0 = ALUCTRL_W'(4'b0110);
               FN_AND:  alu_p0 = ALUCTRL_W'(4'b0000);
               FN_OR:   alu_p0 = ALUCTRL_W'(4'b0001);
               FN_SLT:  alu_p0 = ALUCTRL_W'(4'b0111);
               FN_NOR: begin
                  if (ALUCTRL_W == 4) alu_p0 = ALUCTRL_W'(4'b1100);
                  else                bad_p0 = 1'b1;
               end
               default: bad_p0 = 1'b1;
            endcase
         end
         OP_LW: begin
            rw_p0 = 1'b1; alu_src_p0 = 1'b1; m2r_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0010);
         end
         OP_SW: begin
            mw_p0 = 1'b1; alu_src_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0010);
         end
         OP_BEQ:  begin beq_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0110); end
         OP_BNE:  begin bne_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0110); end
         OP_ADDI: begin rw_p0 = 1'b1; alu_src_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0010); end
         OP_ANDI: begin
            rw_p0 = 1'b1; alu_src_p0 = 1'b1; zero_ext_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0000);
         end
         OP_ORI: begin
            rw_p0 = 1'b1; alu_src_p0 = 1'b1; zero_ext_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0001);
         end
         OP_SLTI: begin rw_p0 = 1'b1; alu_src_p0 = 1'b1; alu_p0 = ALUCTRL_W'(4'b0111); end
         OP_J:    ;
         default: bad_p0 = 1'b1;
      endcase
      // An unrecognised encoding never produces side effects, with or without the trap flag
      if (bad_p0) begin
         alu_src_p0  = 1'b0;
         reg_dst_p0  = 1'b0;
         zero_ext_p0 = 1'b0;
         rw_p0       = 1'b0;
         alu_p0      = '0;
      end
   end

   assign jump_d = (op == OP_J);

   logic                 alu_src_p1, reg_dst_p1, zero_ext_p1;
   logic                 rw_p1, m2r_p1, mw_p1, beq_p1, bne_p1, vld_p1;
   logic [ALUCTRL_W-1:0] alu_p1;
   logic                 mw_p2, beq_p2, bne_p2, zero_p2;
   logic                 rw_p2  [MEM_LAT];
   logic                 m2r_p2 [MEM_LAT];
   logic                 vld_p2 [MEM_LAT];
   logic                 rw_p3, m2r_p3, vld_p3;
`ifdef CTL_ILLEGAL_TRAP_EN
   logic                 ill_p1, ill_p3;
   logic                 ill_p2 [MEM_LAT];
`endif

   // A taken branch in M1 squashes the two younger instructions in D and E
   logic ld_e, ld_m;
   assign pcsrc_m = vld_p2[0] & ((beq_p2 & zero_p2) | (bne_p2 & ~zero_p2));
   assign ld_e    = ~(pcsrc_m | flush_e);
   assign ld_m    = ~pcsrc_m;

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_src_p1  <= 1'b0;
         reg_dst_p1  <= 1'b0;
         zero_ext_p1 <= 1'b0;
         alu_p1      <= '0;
         rw_p1       <= 1'b0;
         m2r_p1      <= 1'b0;
         mw_p1       <= 1'b0;
         beq_p1      <= 1'b0;
         bne_p1      <= 1'b0;
         vld_p1      <= 1'b0;
         mw_p2       <= 1'b0;
         beq_p2      <= 1'b0;
         bne_p2      <= 1'b0;
         zero_p2     <= 1'b0;
         for (int i = 0; i < MEM_LAT; i++) begin
            rw_p2[i]  <= 1'b0;
            m2r_p2[i] <= 1'b0;
            vld_p2[i] <= 1'b0;
`ifdef CTL_ILLEGAL_TRAP_EN
            ill_p2[i] <= 1'b0;
`endif
         end
         rw_p3       <= 1'b0;
         m2r_p3      <= 1'b0;
         vld_p3      <= 1'b0;
`ifdef CTL_ILLEGAL_TRAP_EN
         ill_p1      <= 1'b0;
         ill_p3      <= 1'b0;
`endif
      end else if (!stall) begin
         // D -> E
         alu_src_p1  <= alu_src_p0 & ld_e;
         reg_dst_p1  <= reg_dst_p0 & ld_e;
         zero_ext_p1 <= zero_ext_p0 & ld_e;
         alu_p1      <= ld_e ? alu_p0 : '0;
         rw_p1       <= rw_p0 & ld_e;
         m2r_p1      <= m2r_p0 & ld_e;
         mw_p1       <= mw_p0 & ld_e;
         beq_p1      <= beq_p0 & ld_e;
         bne_p1      <= bne_p0 & ld_e;
         vld_p1      <= ld_e;
`ifdef CTL_ILLEGAL_TRAP_EN
         ill_p1      <= bad_p0 & ld_e;
`endif
         // E -> M1
         mw_p2       <= mw_p1 & ld_m;
         beq_p2      <= beq_p1 & ld_m;
         bne_p2      <= bne_p1 & ld_m;
         zero_p2     <= zero_e & ld_m;
         rw_p2[0]    <= rw_p1 & ld_m;
         m2r_p2[0]   <= m2r_p1 & ld_m;
         vld_p2[0]   <= vld_p1 & ld_m;
`ifdef CTL_ILLEGAL_TRAP_EN
         ill_p2[0]   <= ill_p1 & ld_m;
`endif
         // M1 -> M[MEM_LAT]
         for (int i = 1; i < MEM_LAT; i++) begin
            rw_p2[i]  <= rw_p2[i-1];
            m2r_p2[i] <= m2r_p2[i-1];
            vld_p2[i] <= vld_p2[i-1];
`ifdef CTL_ILLEGAL_TRAP_EN
            ill_p2[i] <= ill_p2[i-1];
`endif
         end
         // M[MEM_LAT] -> W
         rw_p3       <= rw_p2[MEM_LAT-1];
         m2r_p3      <= m2r_p2[MEM_LAT-1];
         vld_p3      <= vld_p2[MEM_LAT-1];
`ifdef CTL_ILLEGAL_TRAP_EN
         ill_p3      <= ill_p2[MEM_LAT-1];
`endif
      end
   end

   assign alu_src_e     = alu_src_p1;
   assign reg_dst_e     = reg_dst_p1;
   assign zero_ext_e    = zero_ext_p1;
   assign alu_control_e = alu_p1;
   assign reg_write_e   = rw_p1;
   assign mem_to_reg_e  = m2r_p1;
   assign mem_write_m   = mw_p2;
   assign reg_write_m   = rw_p2[0];
   assign mem_to_reg_m  = m2r_p2[0];
   assign reg_write_w   = rw_p3;
   assign mem_to_reg_w  = m2r_p3;
   assign valid_w       = vld_p3;
`ifdef CTL_ILLEGAL_TRAP_EN
   assign illegal_w     = ill_p3;
`else
   assign illegal_w     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two configurations (MEM_LAT=1/ALUCTRL_W=3 and MEM_LAT=3/ALUCTRL_W=4)
// checked every cycle against an instruction-record pipeline model, plus directed literal checks.
module tb_pipe_ctrl_unit;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR = 6'b100101, FN_NOR = 6'b100111, FN_SLT = 6'b101010;

   bit clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, zero_e, stall, flush_e;
   logic [5:0] op, funct;

   logic       a_jump_d, a_alu_src_e, a_reg_dst_e, a_zero_ext_e, a_reg_write_e, a_mem_to_reg_e;
   logic       a_mem_write_m, a_reg_write_m, a_mem_to_reg_m, a_pcsrc_m;
   logic       a_reg_write_w, a_mem_to_reg_w, a_valid_w, a_illegal_w;
   logic [2:0] a_alu;
   logic       b_jump_d, b_alu_src_e, b_reg_dst_e, b_zero_ext_e, b_reg_write_e, b_mem_to_reg_e;
   logic       b_mem_write_m, b_reg_write_m, b_mem_to_reg_m, b_pcsrc_m;
   logic       b_reg_write_w, b_mem_to_reg_w, b_valid_w, b_illegal_w;
   logic [3:0] b_alu;

   pipe_ctrl_unit #(.MEM_LAT(1), .ALUCTRL_W(3)) dut_a (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero_e(zero_e), .stall(stall),
      .flush_e(flush_e), .jump_d(a_jump_d), .alu_src_e(a_alu_src_e), .reg_dst_e(a_reg_dst_e),
      .zero_ext_e(a_zero_ext_e), .alu_control_e(a_alu), .reg_write_e(a_reg_write_e),
      .mem_to_reg_e(a_mem_to_reg_e), .mem_write_m(a_mem_write_m), .reg_write_m(a_reg_write_m),
      .mem_to_reg_m(a_mem_to_reg_m), .pcsrc_m(a_pcsrc_m), .reg_write_w(a_reg_write_w),
      .mem_to_reg_w(a_mem_to_reg_w), .valid_w(a_valid_w), .illegal_w(a_illegal_w));

   pipe_ctrl_unit #(.MEM_LAT(3), .ALUCTRL_W(4)) dut_b (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero_e(zero_e), .stall(stall),
      .flush_e(flush_e), .jump_d(b_jump_d), .alu_src_e(b_alu_src_e), .reg_dst_e(b_reg_dst_e),
      .zero_ext_e(b_zero_ext_e), .alu_control_e(b_alu), .reg_write_e(b_reg_write_e),
      .mem_to_reg_e(b_mem_to_reg_e), .mem_write_m(b_mem_write_m), .reg_write_m(b_reg_write_m),
      .mem_to_reg_m(b_mem_to_reg_m), .pcsrc_m(b_pcsrc_m), .reg_write_w(b_reg_write_w),
      .mem_to_reg_w(b_mem_to_reg_w), .valid_w(b_valid_w), .illegal_w(b_illegal_w));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One in-flight instruction, described by what it asks of the datapath
   typedef struct packed {
      bit v, ill, rw, m2r, mw, beq, bne, zero, asrc, rdst, zext;
      bit [3:0] alu;
   } rec_t;

   function automatic rec_t ill_rec();
      rec_t r = '0;
      r.v = 1'b1;
`ifdef CTL_ILLEGAL_TRAP_EN
      r.ill = 1'b1;
`endif
      return r;
   endfunction

   function automatic rec_t dec(input logic [5:0] o, input logic [5:0] f, input bit wide);
      rec_t r = '0;
      r.v = 1'b1;
      case (o)
         OP_R: begin
            r.rw = 1; r.rdst = 1;
            case (f)
               FN_ADD: r.alu = 4'd2;
               FN_SUB: r.alu = 4'd6;
               FN_AND: r.alu = 4'd0;
               FN_OR:  r.alu = 4'd1;
               FN_SLT: r.alu = 4'd7;
               FN_NOR: if (wide) r.alu = 4'd12; else r = ill_rec();
               default: r = ill_rec();
            endcase
         end
         OP_LW:   begin r.rw = 1; r.asrc = 1; r.m2r = 1; r.alu = 4'd2; end
         OP_SW:   begin r.mw = 1; r.asrc = 1; r.alu = 4'd2; end
         OP_BEQ:  begin r.beq = 1; r.alu = 4'd6; end
         OP_BNE:  begin r.bne = 1; r.alu = 4'd6; end
         OP_ADDI: begin r.rw = 1; r.asrc = 1; r.alu = 4'd2; end
         OP_ANDI: begin r.rw = 1; r.asrc = 1; r.zext = 1; r.alu = 4'd0; end
         OP_ORI:  begin r.rw = 1; r.asrc = 1; r.zext = 1; r.alu = 4'd1; end
         OP_SLTI: begin r.rw = 1; r.asrc = 1; r.alu = 4'd7; end
         OP_J:    ;
         default: r = ill_rec();
      endcase
      return r;
   endfunction

   function automatic bit taken(input rec_t m);
      return m.v && ((m.beq && m.zero) || (m.bne && !m.zero));
   endfunction

   // pm[k][0] = E, [1..lat] = M slots, [lat+1] = W
   rec_t pm [2][6];
   int   lat [2] = '{1, 3};

   task automatic step(input int k);
      int L = lat[k];
      bit tk;
      if (reset) begin
         for (int i = 0; i < 6; i++) pm[k][i] = '0;
      end else if (!stall) begin
         tk = taken(pm[k][1]);
         for (int i = L + 1; i >= 2; i--) pm[k][i] = pm[k][i-1];
         pm[k][1] = tk ? rec_t'(0) : pm[k][0];
         if (!tk) pm[k][1].zero = zero_e;
         pm[k][0] = (tk || flush_e) ? rec_t'(0) : dec(op, funct, k == 1);
      end
   endtask

   always @(posedge clk) begin
      step(0);
      step(1);
   end

   task automatic cmp_all(input int k, input string nm, input logic jd, input logic as_, input logic rd,
                          input logic ze, input logic [3:0] alu, input logic rwe, input logic m2re,
                          input logic mwm, input logic rwm, input logic m2rm, input logic pc,
                          input logic rww, input logic m2rw, input logic vw, input logic ilw);
      rec_t e, m, w;
      e = pm[k][0];
      m = pm[k][1];
      w = pm[k][lat[k] + 1];
      check({nm, ".jump_d"},        jd,   op == OP_J);
      check({nm, ".alu_src_e"},     as_,  e.asrc);
      check({nm, ".reg_dst_e"},     rd,   e.rdst);
      check({nm, ".zero_ext_e"},    ze,   e.zext);
      check({nm, ".alu_control_e"}, alu,  e.alu & ((k == 0) ? 4'h7 : 4'hF));
      check({nm, ".reg_write_e"},   rwe,  e.rw);
      check({nm, ".mem_to_reg_e"},  m2re, e.m2r);
      check({nm, ".mem_write_m"},   mwm,  m.mw);
      check({nm, ".reg_write_m"},   rwm,  m.rw);
      check({nm, ".mem_to_reg_m"},  m2rm, m.m2r);
      check({nm, ".pcsrc_m"},       pc,   taken(m));
      check({nm, ".reg_write_w"},   rww,  w.rw);
      check({nm, ".mem_to_reg_w"},  m2rw, w.m2r);
      check({nm, ".valid_w"},       vw,   w.v);
      check({nm, ".illegal_w"},     ilw,  w.ill);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_all(0, "A", a_jump_d, a_alu_src_e, a_reg_dst_e, a_zero_ext_e, {1'b0, a_alu}, a_reg_write_e,
                 a_mem_to_reg_e, a_mem_write_m, a_reg_write_m, a_mem_to_reg_m, a_pcsrc_m,
                 a_reg_write_w, a_mem_to_reg_w, a_valid_w, a_illegal_w);
         cmp_all(1, "B", b_jump_d, b_alu_src_e, b_reg_dst_e, b_zero_ext_e, b_alu, b_reg_write_e,
                 b_mem_to_reg_e, b_mem_write_m, b_reg_write_m, b_mem_to_reg_m, b_pcsrc_m,
                 b_reg_write_w, b_mem_to_reg_w, b_valid_w, b_illegal_w);
      end
   end

   // Apply one cycle of inputs, then return 2 time units after the capturing edge
   task automatic cyc(input logic [5:0] o, input logic [5:0] f = 6'b0, input logic z = 1'b0,
                      input logic s = 1'b0, input logic fl = 1'b0, input logic r = 1'b0);
      op = o; funct = f; zero_e = z; stall = s; flush_e = fl; reset = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      cyc(OP_J, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      cyc(OP_J, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rst.a.reg_write_w", a_reg_write_w, 0);
      check("rst.a.valid_w", a_valid_w, 0);
      check("rst.a.alu_control_e", a_alu, 0);
      check("rst.b.valid_w", b_valid_w, 0);

      // LW latency with MEM_LAT=1
      cyc(OP_LW);
      check("lw.alu_src_e", a_alu_src_e, 1);
      check("lw.alu_control_e", a_alu, 3'b010);
      cyc(OP_J);
      check("lw.mem_to_reg_m", a_mem_to_reg_m, 1);
      check("lw.mem_write_m", a_mem_write_m, 0);
      cyc(OP_J);
      check("lw.reg_write_w", a_reg_write_w, 1);
      check("lw.mem_to_reg_w", a_mem_to_reg_w, 1);
      check("lw.valid_w", a_valid_w, 1);

      // BEQ taken squashes ADD and SUB
      cyc(OP_BEQ);
      cyc(OP_R, FN_ADD, 1'b1);
      check("beq.pcsrc_m", a_pcsrc_m, 1);
      cyc(OP_R, FN_SUB);
      check("beq.pcsrc_after", a_pcsrc_m, 0);
      check("beq.reg_write_m", a_reg_write_m, 0);
      check("beq.reg_write_e", a_reg_write_e, 0);
      cyc(OP_J);
      check("beq.reg_write_w1", a_reg_write_w, 0);
      cyc(OP_J);
      check("beq.reg_write_w2", a_reg_write_w, 0);
      cyc(OP_BNE);
      cyc(OP_J, 6'b0, 1'b1);
      check("bne_nt.pcsrc_m", a_pcsrc_m, 0);
      cyc(OP_BNE);
      cyc(OP_J, 6'b0, 1'b0);
      check("bne_t.pcsrc_m", a_pcsrc_m, 1);
      cyc(OP_J);

      // SW held in M1 through a 3-cycle stall
      cyc(OP_SW);
      cyc(OP_J);
      check("sw.mem_write_m", a_mem_write_m, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(OP_J, 6'b0, 1'b1, 1'b1);
         check("sw.stall.mem_write_m", a_mem_write_m, 1);
         check("sw.stall.pcsrc_m", a_pcsrc_m, 0);
      end
      cyc(OP_J);
      check("sw.released.mem_write_m", a_mem_write_m, 0);

      // A taken branch held by stall keeps pcsrc_m up
      cyc(OP_BEQ);
      cyc(OP_J, 6'b0, 1'b1);
      check("brst.pcsrc_m", a_pcsrc_m, 1);
      for (int i = 0; i < 2; i++) begin
         cyc(OP_J, 6'b0, 1'b0, 1'b1);
         check("brst.stall.pcsrc_m", a_pcsrc_m, 1);
      end
      cyc(OP_J);
      check("brst.released.pcsrc_m", a_pcsrc_m, 0);

      // flush_e with ORI in D; ADDI in M1 still retires
      cyc(OP_ADDI);
      cyc(OP_J);
      cyc(OP_ORI, 6'b0, 1'b0, 1'b0, 1'b1);
      check("flush.reg_write_e", a_reg_write_e, 0);
      check("flush.reg_write_w", a_reg_write_w, 1);
      cyc(OP_J);
      cyc(OP_J);
      check("flush.valid_w", a_valid_w, 0);

      // NOR: legal with 4-bit ALU control, illegal with 3-bit
      cyc(OP_R, FN_NOR);
      check("nor.b.alu_control_e", b_alu, 4'b1100);
      check("nor.b.reg_write_e", b_reg_write_e, 1);
      check("nor.a.reg_write_e", a_reg_write_e, 0);
      cyc(OP_J);
      cyc(OP_J);
      check("nor.a.reg_write_w", a_reg_write_w, 0);
      check("nor.a.valid_w", a_valid_w, 1);
`ifdef CTL_ILLEGAL_TRAP_EN
      check("nor.a.illegal_w", a_illegal_w, 1);
`else
      check("nor.a.illegal_w", a_illegal_w, 0);
`endif
      cyc(OP_J);
      check("nor.a.illegal_w_next", a_illegal_w, 0);

      // Remaining decodes, including illegal encodings
      cyc(OP_R, FN_AND);
      cyc(OP_R, FN_OR);
      cyc(OP_R, FN_SLT);
      cyc(OP_ANDI);
      check("andi.zero_ext_e", a_zero_ext_e, 1);
      check("andi.alu_control_e", a_alu, 0);
      cyc(OP_SLTI);
      check("slti.b.alu_control_e", b_alu, 4'b0111);
      check("slti.b.alu_src_e", b_alu_src_e, 1);
      cyc(OP_ORI);
      cyc(OP_R, 6'b000000);
      cyc(6'b111111);
      cyc(OP_LW);
      cyc(OP_J);
      cyc(OP_J);
      cyc(OP_J);
      cyc(OP_J);

      // Reset while ADDI sits in M2 of the MEM_LAT=3 instance
      cyc(OP_ADDI);
      cyc(OP_J);
      cyc(OP_J);
      cyc(OP_J, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("mrst.b.reg_write_w", b_reg_write_w, 0);
      check("mrst.b.valid_w", b_valid_w, 0);
      check("mrst.b.reg_write_m", b_reg_write_m, 0);
      check("mrst.b.reg_write_e", b_reg_write_e, 0);
      check("mrst.b.alu_control_e", b_alu, 0);
      check("mrst.b.pcsrc_m", b_pcsrc_m, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(OP_J);
         check("mrst.b.reg_write_w_after", b_reg_write_w, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parameterised pipelined MIPS control unit for the 5-stage core. Decodes `op`/`funct` in Decode and carries control bits through E, M and W pipeline registers with per-stage valid bits. Supports hazard-unit stall and flush, branch resolution in M with self-squash, and a configurable memory-stage depth. Sits between the instruction register (D stage) and the datapath/hazard unit.

## Interface
- `MEM_LAT`, 1: number of M-stage register slots between E and W (1..4).
- `ALUCTRL_W`, 3: ALU control width (3 or 4); 4 enables NOR.
- `clk  in  1`: clock, rising edge.
- `reset  in  1`: synchronous, active-high; one clock, reset synchronous active-high.
- `op  in  6`: D-stage opcode.
- `funct  in  6`: D-stage function field.
- `zero_e  in  1`: ALU zero flag from E.
- `stall  in  1`: freeze all controller pipeline registers.
- `flush_e  in  1`: load a bubble into E (hazard unit).
- `jump_d  out  1`: J decoded in D (combinational).
- `alu_src_e, reg_dst_e, zero_ext_e  out  1`: E-stage mux selects.
- `alu_control_e  out  ALUCTRL_W`: E-stage ALU op.
- `reg_write_e, mem_to_reg_e  out  1`: forwarded to hazard unit.
- `mem_write_m, reg_write_m, mem_to_reg_m  out  1`: first M slot.
- `pcsrc_m  out  1`: branch taken; also the squash request to datapath.
- `reg_write_w, mem_to_reg_w, valid_w  out  1`: W-stage controls.
- `illegal_w  out  1`: illegal-instruction flag at W (see Configuration).

## Operation
- Decode (D, combinational): R-type (ADD 010, SUB 110, AND 000, OR 001, SLT 111; NOR 1100 only when ALUCTRL_W=4), LW, SW, BEQ, BNE, ADDI (add), ANDI (and, zero_ext), ORI (or, zero_ext), SLTI (slt), J. 3-bit codes zero-extended when ALUCTRL_W=4.
- Illegal op/funct: all controls 0, valid bit 1, illegal bit 1. Never X.
- Pipeline: D→E register, E→M1 register, M1→…→M[MEM_LAT]→W. mem_write is consumed at M1 only. Branch/BNE/zero are captured into M1.
- pcsrc_m = valid_m1 & ((beq_m1 & zero_m1) | (bne_m1 & ~zero_m1)).
- Bubble = all control bits 0, valid 0, illegal 0.
- Priority at each edge: reset > stall > squash/flush > normal advance.
- reset: all pipeline registers become bubbles.
- stall: every register holds, including M1, so pcsrc_m holds.
- pcsrc_m=1 with no stall: E and M1 load bubbles and the older M1 content advances. flush_e is redundant in this case.
- flush_e=1 with pcsrc_m=0: only E loads a bubble; M1 onward advance normally.

## Timing
- Reset values: every registered output is 0. jump_d follows op immediately.
- Latency from decode in D to use: E +1 cycle, M1 +2, W +2+MEM_LAT.
- pcsrc_m is combinational from the M1 register. It is valid the cycle after zero_e is sampled and is asserted for exactly one unstalled cycle per taken branch.
- Reset asserted mid-stream: the next edge clears all stages. Outputs are 0 from that edge until new instructions arrive.
- stall held N cycles: outputs are constant for N cycles, then resume with no loss or duplication.

## Configuration
- `CTL_ILLEGAL_TRAP_EN` defined: the illegal bit is carried through all stages. illegal_w=1 for one cycle when the offending instruction reaches W. While an illegal instruction occupies E or any M slot, its reg_write and mem_write are forced 0.
- Undefined: the illegal bit is not stored. An illegal op decodes as a NOP (valid, no effects), and illegal_w is tied to 0.

## Test plan
- Reset, then LW (op 100011) in D, MEM_LAT=1 → cycle+1: alu_src_e=1, alu_control_e=010; +2: mem_to_reg_m=1, mem_write_m=0; +3: reg_write_w=1, mem_to_reg_w=1, valid_w=1.
- BEQ with zero_e=1, followed by ADD and SUB → pcsrc_m=1 for one cycle. ADD/SUB never assert reg_write_m or reg_write_w. BNE with zero_e=1 → pcsrc_m=0.
- SW, then stall=1 for 3 cycles with SW in M1 → mem_write_m=1 held for 4 cycles, and pcsrc_m is unchanged during the stall.
- flush_e=1 while ORI is in D → next cycle reg_write_e=0 and valid=0. The older instruction in M1 still reaches W with reg_write_w=1.
- R-type funct 100111: with ALUCTRL_W=4 → alu_control_e=1100; with ALUCTRL_W=3 and CTL_ILLEGAL_TRAP_EN → illegal_w=1 at +2+MEM_LAT, reg_write_w=0.
- MEM_LAT=3, reset asserted while ADDI is in M2 → next cycle all outputs 0, and reg_write_w is never asserted for that ADDI.
